// File: rtl/control_subcmd_fillarea_pattern.sv
// control_subcmd_fillarea_pattern
//
// Fills a clipped rectangle of the framebuffer with a colour pattern
// (solid, checkerboard, row stripes, column stripes), one colour byte per
// clock, under the enable/done/ack handshake shared by the control
// subcommands.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              level-sensitive start request / hold
//   ack                 acknowledges done
//   x1, y1              top-left corner of the rectangle
//   width, height       rectangle size (clipped to the panel)
//   mode                00 solid, 01 checker, 10 row stripes, 11 column stripes
//   color, color_alt    primary / secondary colour
//   ram_ready           (only with CONTROL_FILLAREA_BACKPRESSURE_EN) RAM can
//                       accept the presented byte
//   row, column, pixel  write address (pixel = byte select)
//   data_out            byte to write
//   ram_write_enable    write strobe
//   ram_access_start    one-cycle pulse with the first accepted write
//   done                fill complete, held until ack
//
// Optional feature macro: CONTROL_FILLAREA_BACKPRESSURE_EN adds ram_ready;
// without it the RAM is treated as always ready.
// _UNUSED is a reserved parameter and has no function.

module control_subcmd_fillarea_pattern #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 4,
  parameter int PIXEL_WIDTH     = 8,
  parameter int _UNUSED         = 0,
  localparam int CB = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int RB = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int PB = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  localparam int CW = 8 * BYTES_PER_PIXEL + 0 * _UNUSED
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          ack,
  input  logic [CB-1:0] x1,
  input  logic [RB-1:0] y1,
  input  logic [CB:0]   width,
  input  logic [RB:0]   height,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] color,
  input  logic [CW-1:0] color_alt,
`ifdef CONTROL_FILLAREA_BACKPRESSURE_EN
  input  logic          ram_ready,
`endif
  output logic [RB-1:0] row,
  output logic [CB-1:0] column,
  output logic [PB-1:0] pixel,
  output logic [7:0]    data_out,
  output logic          ram_write_enable,
  output logic          ram_access_start,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CB+1:0] W_EXT   = (CB+2)'(PIXEL_WIDTH);
  localparam logic [RB+1:0] H_EXT   = (RB+2)'(PIXEL_HEIGHT);
  localparam logic [PB-1:0] PIX_TOP = PB'(BYTES_PER_PIXEL - 1);

  state_t        state;
  logic [RB-1:0] row_q;
  logic [CB-1:0] col_q;
  logic [PB-1:0] pix_q;
  logic [7:0]    data_q;
  logic          we_q, start_q, done_q;
  logic          need_low_q;   // enable must be seen low before another start
  logic [CB-1:0] x1_q;
  logic [RB-1:0] y1_q;
  logic [CB:0]   xend_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] color_q, alt_q;
  logic          ready;

`ifdef CONTROL_FILLAREA_BACKPRESSURE_EN
  assign ready = ram_ready;
`else
  assign ready = 1'b1;
`endif

  // Pattern choice needs only the parity of the offsets from (x1,y1).
  function automatic logic [7:0] pattern_byte(input logic [1:0]    m,
                                              input logic          rbit,
                                              input logic          cbit,
                                              input logic [CW-1:0] c,
                                              input logic [CW-1:0] a,
                                              input logic [PB-1:0] p);
    logic          use_alt;
    logic [CW-1:0] sel;
    case (m)
      2'b00:   use_alt = 1'b0;
      2'b01:   use_alt = rbit ^ cbit;
      2'b10:   use_alt = rbit;
      default: use_alt = cbit;
    endcase
    sel = (use_alt ? a : c) >> {p, 3'b000};
    return sel[7:0];
  endfunction

  // Clipping on the live inputs; two extra bits keep x1+width from wrapping.
  logic [CB+1:0] xsum_c, xend_c;
  logic [RB+1:0] ysum_c, yend_c;
  logic          empty_c;
  logic [CB-1:0] col0_c;
  logic [RB-1:0] row0_c;

  always_comb begin
    xsum_c  = {2'b00, x1} + {1'b0, width};
    ysum_c  = {2'b00, y1} + {1'b0, height};
    xend_c  = (xsum_c > W_EXT) ? W_EXT : xsum_c;
    yend_c  = (ysum_c > H_EXT) ? H_EXT : ysum_c;
    empty_c = (width == '0) || (height == '0) ||
              ({2'b00, x1} >= W_EXT) || ({2'b00, y1} >= H_EXT);
    col0_c  = CB'(xend_c - 1'b1);
    row0_c  = RB'(yend_c - 1'b1);
  end

  // Next address in the descending pixel/column/row walk.
  logic [RB-1:0] nrow_c;
  logic [CB-1:0] ncol_c;
  logic [PB-1:0] npix_c;
  logic          last_c;

  always_comb begin
    nrow_c = row_q;
    ncol_c = col_q;
    npix_c = pix_q;
    last_c = 1'b0;
    if (pix_q != '0) begin
      npix_c = pix_q - 1'b1;
    end else begin
      npix_c = PIX_TOP;
      if (col_q != x1_q) begin
        ncol_c = col_q - 1'b1;
      end else begin
        ncol_c = CB'(xend_q - 1'b1);
        if (row_q == y1_q) last_c = 1'b1;
        else               nrow_c = row_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      pix_q      <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      need_low_q <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      xend_q     <= '0;
      mode_q     <= '0;
      color_q    <= '0;
      alt_q      <= '0;
    end else begin
      if (!enable) need_low_q <= 1'b0;
      case (state)
        IDLE: begin
          we_q    <= 1'b0;
          start_q <= 1'b0;
          done_q  <= 1'b0;
          if (enable && !ack && !need_low_q) state <= LOAD;
        end
        LOAD: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            x1_q    <= x1;
            y1_q    <= y1;
            xend_q  <= xend_c[CB:0];
            mode_q  <= mode;
            color_q <= color;
            alt_q   <= color_alt;
            if (empty_c) begin
              state      <= DONE;
              done_q     <= 1'b1;
              need_low_q <= 1'b1;
            end else begin
              state   <= WRITE;
              row_q   <= row0_c;
              col_q   <= col0_c;
              pix_q   <= PIX_TOP;
              data_q  <= pattern_byte(mode, row0_c[0] ^ y1[0], col0_c[0] ^ x1[0],
                                      color, color_alt, PIX_TOP);
              we_q    <= 1'b1;
              start_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (!enable) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            start_q <= 1'b0;
          end else if (ready) begin
            // The presented byte was accepted on this edge.
            start_q <= 1'b0;
            if (last_c) begin
              state      <= DONE;
              we_q       <= 1'b0;
              done_q     <= 1'b1;
              need_low_q <= 1'b1;
            end else begin
              row_q  <= nrow_c;
              col_q  <= ncol_c;
              pix_q  <= npix_c;
              data_q <= pattern_byte(mode_q, nrow_c[0] ^ y1_q[0], ncol_c[0] ^ x1_q[0],
                                     color_q, alt_q, npix_c);
            end
          end
        end
        DONE: begin
          if (ack) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign row              = row_q;
  assign column           = col_q;
  assign pixel            = pix_q;
  assign data_out         = data_q;
  assign ram_write_enable = we_q & ready;
  assign ram_access_start = start_q & ready;
  assign done             = done_q;

endmodule

// File: tb/tb_control_subcmd_fillarea_pattern.sv
// Testbench for control_subcmd_fillarea_pattern on an 8x4 panel with two
// bytes per pixel. A reference list of writes is built from the fill rules
// for each command and every write strobe is matched against it in order.

module tb_control_subcmd_fillarea_pattern;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int BPP = 2;

  logic        clk = 1'b0;
  logic        reset, enable, ack;
  logic [2:0]  x1;
  logic [1:0]  y1;
  logic [3:0]  width;
  logic [2:0]  height;
  logic [1:0]  mode;
  logic [15:0] color, color_alt;
  logic        ram_ready;
  logic [1:0]  row;
  logic [2:0]  column;
  logic [0:0]  pixel;
  logic [7:0]  data_out;
  logic        ram_write_enable, ram_access_start, done;

  always #5 clk = ~clk;

  control_subcmd_fillarea_pattern #(
    .BYTES_PER_PIXEL(BPP), .PIXEL_HEIGHT(H), .PIXEL_WIDTH(W), ._UNUSED(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ack(ack),
    .x1(x1), .y1(y1), .width(width), .height(height), .mode(mode),
    .color(color), .color_alt(color_alt),
`ifdef CONTROL_FILLAREA_BACKPRESSURE_EN
    .ram_ready(ram_ready),
`endif
    .row(row), .column(column), .pixel(pixel), .data_out(data_out),
    .ram_write_enable(ram_write_enable), .ram_access_start(ram_access_start),
    .done(done)
  );

  typedef struct { int r; int c; int p; int d; } wr_t;
  wr_t  expq[$];
  int   checks = 0, errors = 0;
  int   nwrites = 0, exp_n = 0, maxcol = -1, first_row = -1, first_col = -1;
  logic [7:0] logm [0:H-1][0:W-1][0:BPP-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pat_byte(int m, int rr, int cc, int c, int a, int p);
    int use_alt;
    case (m)
      0:       use_alt = 0;
      1:       use_alt = (rr + cc) % 2;
      2:       use_alt = rr % 2;
      default: use_alt = cc % 2;
    endcase
    return ((use_alt != 0 ? a : c) >> (8 * p)) & 255;
  endfunction

  function automatic int out_word();
    return int'({row, column, pixel, data_out});
  endfunction

  // Reference write list: every pixel byte of the clipped rectangle, bottom
  // row first, rightmost column first, most significant byte first.
  task automatic build_expected(input int x, input int y, input int w, input int h,
                                input int m, input int c, input int a, output int n);
    int xe, ye;
    xe = (x + w > W) ? W : x + w;
    ye = (y + h > H) ? H : y + h;
    expq.delete();
    n = 0;
    for (int r = ye - 1; r >= y; r--)
      for (int cc = xe - 1; cc >= x; cc--)
        for (int p = BPP - 1; p >= 0; p--) begin
          wr_t e;
          e.r = r; e.c = cc; e.p = p;
          e.d = pat_byte(m, r - y, cc - x, c, a, p);
          expq.push_back(e);
          n++;
        end
  endtask

  // Compare process: every write strobe must match the head of the list.
  always @(negedge clk) begin
    wr_t e;
    if (ram_write_enable === 1'b1) begin
      nwrites++;
      chk("start_pulse", ram_access_start, nwrites == 1);
      if (int'(column) > maxcol) maxcol = int'(column);
      if (nwrites == 1) begin first_row = int'(row); first_col = int'(column); end
      logm[row][column][pixel] = data_out;
      if (expq.size() == 0) begin
        chk("write_count_excess", nwrites, exp_n);
      end else begin
        e = expq.pop_front();
        chk("write", out_word(), e.r * 4096 + e.c * 512 + e.p * 256 + e.d);
      end
    end else begin
      chk("start_without_write", ram_access_start, 0);
    end
  end

  task automatic start_cmd(input int x, input int y, input int w, input int h,
                           input int m, input int c, input int a);
    int n;
    build_expected(x, y, w, h, m, c, a, n);
    exp_n = n; nwrites = 0; maxcol = -1; first_row = -1; first_col = -1;
    @(negedge clk);
    x1 = x[2:0]; y1 = y[1:0]; width = w[3:0]; height = h[2:0];
    mode = m[1:0]; color = c[15:0]; color_alt = a[15:0];
    enable = 1'b1; ack = 1'b0;
  endtask

  task automatic wait_writes(input int k);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (nwrites >= k) return;
    end
    chk("wait_writes_timeout", nwrites, k);
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h, input int m,
                         input int c, input int a, input int stall, input bit hold_en);
    int cyc, stall_left, held;
    bit stalled;
    start_cmd(x, y, w, h, m, c, a);
    cyc = 0; stall_left = 0; stalled = 0; held = 0;
    while (cyc < 400) begin
      @(posedge clk); cyc++; #1;
      if (stall_left > 0) begin
        chk("stall_hold", out_word(), held);
        stall_left--;
        if (stall_left == 0) ram_ready = 1'b1;
      end else if (stall > 0 && !stalled && nwrites == 4) begin
        ram_ready = 1'b0; stall_left = stall; stalled = 1; held = out_word();
      end
      @(negedge clk); #1;
      if (done === 1'b1) break;
    end
    chk("done_latency", cyc, exp_n + 2 + stall);
    chk("writes_total", nwrites, exp_n);
    chk("queue_drained", expq.size(), 0);
    ack = 1'b1; enable = hold_en;
    @(posedge clk); @(negedge clk); #1;
    chk("done_cleared", done, 0);
    chk("state_idle_after_ack", dut.state, 0);
    ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; ack = 1'b0; ram_ready = 1'b1;
    x1 = '0; y1 = '0; width = '0; height = '0; mode = '0; color = '0; color_alt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, 0);
    chk("reset_state", dut.state, 0);
    reset = 1'b0;

    // Full-panel solid fill with colour 0.
    run_cmd(0, 0, 8, 4, 0, 16'h0000, 16'hFFFF, 0, 0);
    chk("full_count", nwrites, 64);
    chk("full_first_row", first_row, 3);
    chk("full_first_col", first_col, 7);

    // Checkerboard 4x2 at (1,1).
    run_cmd(1, 1, 4, 2, 1, 16'h1234, 16'hABCD, 0, 0);
    chk("chk_count", nwrites, 16);
    chk("chk_11_hi", logm[1][1][1], 8'h12);
    chk("chk_11_lo", logm[1][1][0], 8'h34);
    chk("chk_21_hi", logm[1][2][1], 8'hAB);
    chk("chk_21_lo", logm[1][2][0], 8'hCD);
    chk("chk_42_hi", logm[2][4][1], 8'h12);
    chk("chk_32_lo", logm[2][3][0], 8'hCD);

    // Row stripes and column stripes.
    run_cmd(2, 0, 3, 3, 2, 16'hC3A5, 16'h0F0F, 0, 0);
    chk("rows_r1", logm[1][3][0], 8'h0F);
    chk("rows_r2", logm[2][4][1], 8'hC3);
    run_cmd(0, 1, 5, 2, 3, 16'h1111, 16'hEEEE, 0, 0);
    chk("cols_c1", logm[2][1][0], 8'hEE);
    chk("cols_c0", logm[1][0][1], 8'h11);

    // Clipping at the right edge and at the bottom edge.
    run_cmd(6, 0, 5, 1, 0, 16'h00FF, 16'h0000, 0, 0);
    chk("clip_x_count", nwrites, 4);
    chk("clip_x_maxcol", maxcol, 7);
    run_cmd(3, 2, 2, 7, 1, 16'h7788, 16'h99AA, 0, 0);
    chk("clip_y_count", nwrites, 8);

    // Degenerate sizes.
    run_cmd(3, 1, 0, 2, 0, 16'h4242, 16'h0000, 0, 0);
    chk("zero_width_writes", nwrites, 0);
    run_cmd(3, 1, 2, 0, 0, 16'h4242, 16'h0000, 0, 0);
    chk("zero_height_writes", nwrites, 0);

    // Enable still high after ack: no restart.
    run_cmd(0, 0, 1, 1, 0, 16'h0102, 16'h0000, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("no_restart_state", dut.state, 0);
    chk("no_restart_writes", nwrites, 2);
    enable = 1'b0;

    // Abort by dropping enable mid-fill.
    start_cmd(0, 0, 8, 4, 1, 16'h3C3C, 16'hC3C3);
    wait_writes(3);
    enable = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("abort_we", ram_write_enable, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("abort_done", done, 0);
    chk("abort_state", dut.state, 0);
    chk("abort_writes", nwrites, 3);
    expq.delete();

    // Reset in the middle of a fill, then a fresh command.
    start_cmd(0, 0, 8, 4, 2, 16'h5AA5, 16'h0F0F);
    wait_writes(5);
    reset = 1'b1; enable = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("midreset_outputs", {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, 0);
    chk("midreset_state", dut.state, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midreset_writes", nwrites, 5);
    expq.delete();
    run_cmd(1, 0, 2, 2, 1, 16'h2468, 16'h1357, 0, 0);
    chk("after_reset_count", nwrites, 8);

`ifdef CONTROL_FILLAREA_BACKPRESSURE_EN
    // Three stall cycles in the middle of a fill.
    run_cmd(0, 0, 4, 2, 1, 16'hBEEF, 16'h1234, 3, 0);
    chk("stall_count", nwrites, 16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
